// File: rtl/gpr_pkg.sv
// ---------------------------------------------------------------------------
// gpr_pkg
//   Shared definitions for the general-purpose register file access path:
//   register width, select width, register count and the sequencer state
//   encoding.
// ---------------------------------------------------------------------------
package gpr_pkg;

  localparam int GPR_W     = 12;
  localparam int GPR_SEL_W = 3;
  localparam int GPR_NUM   = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_STB  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_STB  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RSP     = 3'd5
  } gpr_state_e;

endpackage

// File: rtl/gpr_strobe_timer.sv
// ---------------------------------------------------------------------------
// gpr_strobe_timer
//   Down-counter that times one register-file phase: STROBE_CYCLES cycles of
//   strobe followed by WAIT_CYCLES cycles of settle time.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start    in   (re)load the counter; the phase begins next cycle
//   pulse    out  high during the strobe portion of the phase
//   stb_last out  high in the last strobe cycle
//   done     out  high in the last settle cycle
// ---------------------------------------------------------------------------
module gpr_strobe_timer
  import gpr_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic pulse,
  output logic stb_last,
  output logic done
);

  localparam int TOTAL = STROBE_CYCLES + WAIT_CYCLES;
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Count runs TOTAL-1 .. 0; values >= WAIT_CYCLES are the strobe part.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = CNT_W'(TOTAL - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign pulse    = active_q && (cnt_q >= CNT_W'(WAIT_CYCLES));
  assign stb_last = active_q && (cnt_q == CNT_W'(WAIT_CYCLES));
  assign done     = active_q && (cnt_q == '0);

endmodule

// File: rtl/gpr_access_seq.sv
// ---------------------------------------------------------------------------
// gpr_access_seq
//   Initiator for the 8 x 12-bit register file port. Accepts a request
//   (optional write phase, then optional read phase), drives the register
//   file's level-sensitive enables with strobe/settle timing, captures both
//   read results and returns them through a valid/ready response.
//
// Ports:
//   iCLK, iRST                 clock, synchronous active-high reset
//   iREQ_VALID / oREQ_READY    request handshake (ready only in IDLE)
//   iREQ_RD, iREQ_WR           request includes read / write phase
//   iREQ_RS0/RS1/RDEST/WDATA   read selects, write select, write data
//   oRSP_VALID / iRSP_READY    response handshake
//   oRSP_DATA0/1               captured read data (0 when no read phase)
//   oGPR_RD_EN, oGPR_WR_EN     register file enables
//   oGPR_RDREG0/1, oGPR_WRREG  register file selects
//   oGPR_DATA                  register file write data
//   iGPR_DATA0/1               register file read data
// ---------------------------------------------------------------------------
module gpr_access_seq
  import gpr_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iREQ_VALID,
  output logic                 oREQ_READY,
  input  logic                 iREQ_RD,
  input  logic                 iREQ_WR,
  input  logic [GPR_SEL_W-1:0] iREQ_RS0,
  input  logic [GPR_SEL_W-1:0] iREQ_RS1,
  input  logic [GPR_SEL_W-1:0] iREQ_RDEST,
  input  logic [GPR_W-1:0]     iREQ_WDATA,
  output logic                 oRSP_VALID,
  input  logic                 iRSP_READY,
  output logic [GPR_W-1:0]     oRSP_DATA0,
  output logic [GPR_W-1:0]     oRSP_DATA1,
  output logic                 oGPR_RD_EN,
  output logic                 oGPR_WR_EN,
  output logic [GPR_SEL_W-1:0] oGPR_RDREG0,
  output logic [GPR_SEL_W-1:0] oGPR_RDREG1,
  output logic [GPR_SEL_W-1:0] oGPR_WRREG,
  output logic [GPR_W-1:0]     oGPR_DATA,
  input  logic [GPR_W-1:0]     iGPR_DATA0,
  input  logic [GPR_W-1:0]     iGPR_DATA1
);

  if (STROBE_CYCLES < 1) begin : g_bad_strobe
    $fatal(1, "gpr_access_seq: STROBE_CYCLES must be >= 1");
  end
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $fatal(1, "gpr_access_seq: WAIT_CYCLES must be >= 1");
  end

  gpr_state_e           state_q, state_d;
  logic                 req_rd_q, req_rd_d;
  logic [GPR_SEL_W-1:0] rdreg0_q, rdreg0_d;
  logic [GPR_SEL_W-1:0] rdreg1_q, rdreg1_d;
  logic [GPR_SEL_W-1:0] wrreg_q, wrreg_d;
  logic [GPR_W-1:0]     gpr_data_q, gpr_data_d;
  logic                 rd_en_q, rd_en_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [GPR_W-1:0]     rsp_data0_q, rsp_data0_d;
  logic [GPR_W-1:0]     rsp_data1_q, rsp_data1_d;

  logic tmr_start, tmr_pulse, tmr_stb_last, tmr_done;

  gpr_strobe_timer #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .WAIT_CYCLES   (WAIT_CYCLES)
  ) u_timer (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (tmr_start),
    .pulse    (tmr_pulse),
    .stb_last (tmr_stb_last),
    .done     (tmr_done)
  );

  // Outputs are a registered decode of the current state, so every pin lags
  // the state by one cycle: a state entered at edge k shows on the pins at
  // edge k+1.
  always_comb begin
    state_d     = state_q;
    req_rd_d    = req_rd_q;
    rdreg0_d    = rdreg0_q;
    rdreg1_d    = rdreg1_q;
    wrreg_d     = wrreg_q;
    gpr_data_d  = gpr_data_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    tmr_start   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iREQ_VALID) begin
          req_rd_d    = iREQ_RD;
          rdreg0_d    = iREQ_RS0;
          rdreg1_d    = iREQ_RS1;
          wrreg_d     = iREQ_RDEST;
          gpr_data_d  = iREQ_WDATA;
          rsp_data0_d = '0;
          rsp_data1_d = '0;
          if (iREQ_WR) begin
            state_d   = S_WR_STB;
            tmr_start = 1'b1;
          end else if (iREQ_RD) begin
            state_d   = S_RD_STB;
            tmr_start = 1'b1;
          end else begin
            state_d = S_RSP;
          end
        end
      end
      S_WR_STB: begin
        if (tmr_stb_last) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (tmr_done) begin
          if (req_rd_q) begin
            state_d   = S_RD_STB;
            tmr_start = 1'b1;
          end else begin
            state_d = S_RSP;
          end
        end
      end
      S_RD_STB: begin
        if (tmr_stb_last) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (tmr_done) begin
          rsp_data0_d = iGPR_DATA0;
          rsp_data1_d = iGPR_DATA1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_valid_q && iRSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_en_d     = tmr_pulse && (state_q == S_WR_STB);
    rd_en_d     = tmr_pulse && (state_q == S_RD_STB);
    rsp_valid_d = (state_q == S_RSP) && !(rsp_valid_q && iRSP_READY);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      req_rd_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      // Selects/data stay put while an enable is falling so the register
      // file sees a clean trailing edge; they clear on a later reset cycle.
      if (!rd_en_q && !wr_en_q) begin
        rdreg0_q   <= '0;
        rdreg1_q   <= '0;
        wrreg_q    <= '0;
        gpr_data_q <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_rd_q    <= req_rd_d;
      rdreg0_q    <= rdreg0_d;
      rdreg1_q    <= rdreg1_d;
      wrreg_q     <= wrreg_d;
      gpr_data_q  <= gpr_data_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign oREQ_READY  = (state_q == S_IDLE);
  assign oRSP_VALID  = rsp_valid_q;
  assign oRSP_DATA0  = rsp_data0_q;
  assign oRSP_DATA1  = rsp_data1_q;
  assign oGPR_RD_EN  = rd_en_q;
  assign oGPR_WR_EN  = wr_en_q;
  assign oGPR_RDREG0 = rdreg0_q;
  assign oGPR_RDREG1 = rdreg1_q;
  assign oGPR_WRREG  = wrreg_q;
  assign oGPR_DATA   = gpr_data_q;

endmodule

// File: doc/gpr_access_seq.md
Name: gpr_access_seq

Overview:
Initiator side of the general-purpose register file port. Accepts operand-read and writeback requests from the control unit through a valid/ready handshake, and drives the register file's level-sensitive read/write enables, register selects and write data with the required setup, strobe and settle timing. Captures both 12-bit read results and returns them through a valid/ready response. It sits between the decode/execute control and the 8 x 12-bit register file.

Parameters:
STROBE_CYCLES, 2, cycles each enable is held high; must be >= 1.
WAIT_CYCLES, 2, cycles after an enable falls before the phase completes; must be >= 1 and cover the register file's internal delay in clock periods.

Ports:
iCLK  in  1  clock; all state changes on the rising edge
iRST  in  1  reset, synchronous, active-high
iREQ_VALID  in  1  request valid
oREQ_READY  out  1  request ready; high only in IDLE
iREQ_RD  in  1  request includes a read phase
iREQ_WR  in  1  request includes a write phase
iREQ_RS0  in  3  read select 0
iREQ_RS1  in  3  read select 1
iREQ_RDEST  in  3  write select
iREQ_WDATA  in  12  write data
oRSP_VALID  out  1  response valid
iRSP_READY  in  1  response accepted
oRSP_DATA0  out  12  captured read data 0
oRSP_DATA1  out  12  captured read data 1
oGPR_RD_EN  out  1  register-file read enable
oGPR_WR_EN  out  1  register-file write enable
oGPR_RDREG0  out  3  register-file read select 0
oGPR_RDREG1  out  3  register-file read select 1
oGPR_WRREG  out  3  register-file write select
oGPR_DATA  out  12  register-file write data
iGPR_DATA0  in  12  register-file read data 0
iGPR_DATA1  in  12  register-file read data 1

Behaviour:
- States: IDLE, WR_STB, WR_WAIT, RD_STB, RD_WAIT, RSP. All outputs are registered except oREQ_READY, which is decoded from state == IDLE.
- Acceptance happens on iREQ_VALID & oREQ_READY at edge k. All request fields are latched at that edge. oGPR_RDREG0, oGPR_RDREG1, oGPR_WRREG and oGPR_DATA take the latched values at edge k and stay stable until the next acceptance.
- Phase order is fixed: write, then read. A combined request therefore reads back the value just written.
- Write phase: oGPR_WR_EN is high for exactly STROBE_CYCLES cycles starting at edge k+1, then low for WAIT_CYCLES cycles. Both enable edges write the same stable data.
- Read phase: same shape on oGPR_RD_EN. iGPR_DATA0/1 are captured into oRSP_DATA0/1 on the last RD_WAIT edge.
- Response timing: oRSP_VALID rises at edge k+1+P*(STROBE_CYCLES+WAIT_CYCLES), where P is the number of phases (0, 1 or 2). It holds, with stable data, until iRSP_READY is sampled high. The state then returns to IDLE, so oREQ_READY is high at the following cycle. There is no overlap between requests.
- Write-only or empty request: the response is still issued as a completion, and oRSP_DATA0/1 = 0.
- oGPR_RD_EN and oGPR_WR_EN are never high simultaneously. Each enable rises at most once per request.
- Reset (synchronous, active-high) clears:
  - state to IDLE;
  - oRSP_VALID, oRSP_DATA0/1, oGPR_RD_EN and oGPR_WR_EN to 0.
- oGPR_RDREG0/1, oGPR_WRREG and oGPR_DATA clear to 0 on a reset cycle only if both enables were already low. Otherwise they hold, so the enable's falling edge sees consistent select/data; they clear on a later reset cycle.
- Reset mid-operation aborts the request with no response. A write aborted during WR_STB is still committed with the held data.
- oREQ_READY is 1 in the first cycle after reset.

Decomposition:
- Shared package (gpr_pkg): GPR_W=12, GPR_SEL_W=3, GPR_NUM=8, and the state enum encoding.
- One sub-module: gpr_strobe_timer. It is a down-counter that generates a STROBE_CYCLES-high then WAIT_CYCLES-low pulse plus a done flag. It is instantiated once and reused for both phases.
- Elaboration check: fatal error if STROBE_CYCLES < 1 or WAIT_CYCLES < 1.

Test Plan:
1. Reset, then write-only request RDEST=3, WDATA=12'hABC, defaults -> WR_EN high edges k+1..k+2, low k+3..k+4. oRSP_VALID at k+5 with data 0, RD_EN never rises. A subsequent read of RS0=3 returns 12'hABC.
2. Combined request RDEST=5, WDATA=12'h5A5, RS0=5, RS1=3 -> oRSP_VALID at k+9, oRSP_DATA0=12'h5A5, oRSP_DATA1=12'hABC. Enables are never simultaneously high.
3. Response backpressure: iRSP_READY held low for 4 cycles after oRSP_VALID -> VALID and data stable, oREQ_READY low. Ready pulse -> IDLE next cycle.
4. Empty request (RD=WR=0) -> oRSP_VALID at k+1, data 0. Back-to-back requests with iREQ_VALID held high -> exactly one acceptance per IDLE visit.
5. Reset asserted at the second WR_STB cycle of a write RDEST=2, WDATA=12'h123 -> WR_EN 0 next edge, oGPR_WRREG/oGPR_DATA unchanged that cycle, no response. Register 2 later reads 12'h123.
6. STROBE_CYCLES=1, WAIT_CYCLES=4 combined request -> oRSP_VALID at k+11. All enable pulse widths match the parameters.
